up_down_counter_3bit: RTL and testbench



---
 rtl/up_down_counter_3bit_pkg.sv | 5 +
 rtl/d_flip_flop.sv | 16 +
 rtl/mux2_1.sv | 8 +
 rtl/up_down_counter_3bit.sv | 43 ++++
 tb/tb_up_down_counter_3bit.sv | 129 ++++++++++++
 5 files changed

// File: rtl/up_down_counter_3bit_pkg.sv
// up_down_counter_3bit_pkg: shared width and reset constants for the step counter
package up_down_counter_3bit_pkg;
    localparam int WIDTH = 3;
    localparam logic [WIDTH-1:0] RST_VAL = '0;
endpackage

// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge bit cell with sync active-high clear and complementary output
module d_flip_flop (
    input  logic d,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic not_q
);
    logic q_q;
    // bit register, cleared synchronously
    always_ff @(posedge clk) begin
        q_q <= rst ? 1'b0 : d;
    end
    assign q = q_q;
    assign not_q = ~q_q;
endmodule

// File: rtl/mux2_1.sv
// mux2_1: 2:1 selector, sel high picks i[1]
module mux2_1 (
    input  logic [1:0] i,
    input  logic       sel,
    output logic       o
);
    assign o = sel ? i[1] : i[0];
endmodule

// File: rtl/up_down_counter_3bit.sv
// up_down_counter_3bit: 3-bit up/down counter with parallel load, built from bit cells and selectors
module up_down_counter_3bit
    import up_down_counter_3bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             c_up,
    input  logic             c_down,
    input  logic             load,
    input  logic [WIDTH-1:0] initial_value,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] not_q
);
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] state_d;
    logic             hold;
    // load overrides everything; equal up/down requests (both or neither) keep the state
    assign hold = ~load & ~(c_up ^ c_down);
    // next count value; only consumed when exactly one direction is requested
    always_comb begin
        count_d = c_up ? q + 1'b1 : q - 1'b1;
    end
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux2_1 u_load_mux (
            .i   ({initial_value[b], count_d[b]}),
            .sel (load),
            .o   (sel_d[b])
        );
        mux2_1 u_hold_mux (
            .i   ({q[b], sel_d[b]}),
            .sel (hold),
            .o   (state_d[b])
        );
        d_flip_flop u_ff (
            .d     (state_d[b]),
            .clk   (clk),
            .rst   (rst),
            .q     (q[b]),
            .not_q (not_q[b])
        );
    end
endmodule

// File: tb/tb_up_down_counter_3bit.sv
// tb_up_down_counter_3bit: table-driven directed check of the 3-bit up/down counter
module tb_up_down_counter_3bit;
    typedef struct {
        logic       rst;
        logic       load;
        logic       up;
        logic       dn;
        logic [2:0] iv;
        logic [2:0] exp_q;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c_up = 1'b0;
    logic       c_down = 1'b0;
    logic       load = 1'b0;
    logic [2:0] initial_value = 3'd0;
    logic [2:0] q;
    logic [2:0] not_q;
    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    up_down_counter_3bit dut (
        .clk           (clk),
        .rst           (rst),
        .c_up          (c_up),
        .c_down        (c_down),
        .load          (load),
        .initial_value (initial_value),
        .q             (q),
        .not_q         (not_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] exp_q);
        checks += 2;
        if (q !== exp_q) begin
            failures++;
            $display("FAIL %s q got=%0d want=%0d", name, q, exp_q);
        end
        if (not_q !== ~exp_q) begin
            failures++;
            $display("FAIL %s not_q got=%0d want=%0d", name, not_q, ~exp_q);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        load = v.load;
        c_up = v.up;
        c_down = v.dn;
        initial_value = v.iv;
    endtask

    initial begin
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd5});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0});
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'(k)});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd6});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd5});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd4});
        for (int k = 0; k < 2; k++)
            tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd4});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd6});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1});
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), tbl[n].exp_q);
        end
        // a command pulse that ends before the edge must not register
        @(negedge clk);
        c_up = 1'b1;
        #2;
        c_up = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_hold", 3'd1);
        // outputs are registered: a new load is invisible until the edge
        @(negedge clk);
        load = 1'b1;
        initial_value = 3'd6;
        #1;
        check("no_comb_path", 3'd1);
        @(posedge clk);
        #1;
        check("load_after_edge", 3'd6);
        // load wins over a simultaneous down request
        @(negedge clk);
        initial_value = 3'd0;
        c_down = 1'b1;
        @(posedge clk);
        #1;
        check("load_over_down", 3'd0);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
        check("down_wrap", 3'd7);
        @(negedge clk);
        c_down = 1'b0;
        c_up = 1'b1;
        @(posedge clk);
        #1;
        check("up_wrap", 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout q=%0d", q);
        $fatal(1);
    end
endmodule
